// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - E-stage to MDU operand/result bundle
interface e_mdu_if;
  logic [3:0]  op;
  logic        valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op, valid, a, b,
    input  start, busy, stall_req, hi, lo
  );

  modport slave (
    input  op, valid, a, b,
    output start, busy, stall_req, hi, lo
  );
endinterface

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - execute-stage multiply/divide unit holding HI/LO
// Result is computed at accept and committed after a fixed busy countdown.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  e_mdu_if.slave bus
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [31:0] hi_q, lo_q, pend_hi, pend_lo;
  logic        pend_commit;

  logic               is_mul, is_div, start;
  logic [3:0]         load_cnt;
  logic [31:0]        res_hi, res_lo;
  logic               res_commit;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        dvsr_s, dvsr_u;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;

  always_comb begin
    is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    // Gated by reset so nothing looks acceptable while the unit is held.
    start  = reset && bus.valid && (is_mul || is_div) && (state == S_IDLE);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN:  if (cnt == 4'd1) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Divisors are forced to 1 for zero and for the signed overflow case;
  // MIN/1 already yields the required quotient MIN, remainder 0.
  always_comb begin
    prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    prod_u = {32'd0, bus.a} * {32'd0, bus.b};
    dvsr_s = ((bus.b == 32'd0) || (bus.a == 32'h8000_0000 && bus.b == 32'hFFFF_FFFF))
             ? 32'd1 : bus.b;
    dvsr_u = (bus.b == 32'd0) ? 32'd1 : bus.b;
    quot_s = $signed(bus.a) / $signed(dvsr_s);
    rem_s  = $signed(bus.a) % $signed(dvsr_s);
    quot_u = bus.a / dvsr_u;
    rem_u  = bus.a % dvsr_u;
  end

  always_comb begin
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    res_commit = 1'b1;
    load_cnt   = 4'(MULT_CYCLES);
    case (bus.op)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV: begin
        res_hi = rem_s; res_lo = quot_s;
        res_commit = (bus.b != 32'd0);
        load_cnt = 4'(DIV_CYCLES);
      end
      OP_DIVU: begin
        res_hi = rem_u; res_lo = quot_u;
        res_commit = (bus.b != 32'd0);
        load_cnt = 4'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pend_hi     <= 32'd0;
      pend_lo     <= 32'd0;
      pend_commit <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        cnt         <= load_cnt;
        pend_hi     <= res_hi;
        pend_lo     <= res_lo;
        pend_commit <= res_commit;
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1 && pend_commit) begin
          hi_q <= pend_hi;
          lo_q <= pend_lo;
        end
      end
      if (bus.valid && state == S_IDLE) begin
        if (bus.op == OP_MTHI) hi_q <= bus.a;
        if (bus.op == OP_MTLO) lo_q <= bus.a;
      end
    end
  end

  assign bus.start     = start;
  assign bus.busy      = (state == S_RUN);
  assign bus.stall_req = start || (state == S_RUN);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. It sits directly downstream of the D/E pipeline register and consumes its forwarded operands (rs/rt values) together with the decoded MDU opcode.
- Holds the architectural HI/LO registers and models multi-cycle mult/div latency.
- Exports busy/stall-request so hazard logic can freeze F/D and D/E and insert E-stage bubbles while an MDU instruction is pending.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 clears state at the clock edge).
- op  input  4  MDU opcode from D/E: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7..15 treated as none.
- valid  input  1  E-stage instruction is real (0 = bubble; op ignored).
- a  input  32  forwarded rs value (RD1 after E-stage forwarding mux).
- b  input  32  forwarded rt value (RD2 after forwarding).
- start  output  1  combinational: valid & op in {1,2,3,4} & !busy.
- busy  output  1  registered: operation in flight.
- stall_req  output  1  combinational: start | busy; hazard unit ORs this with md-instruction-in-D.
- hi  output  32  HI register contents.
- lo  output  32  LO register contents.

Behaviour:
- Reset (reset==0 at edge): hi=0, lo=0, busy=0, counter=0, pending result=0. Reset mid-operation aborts it; HI/LO are not committed.
- Accept: at an edge with start==1, compute the result from a/b and latch it into internal pend_hi/pend_lo.
  - Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4); busy becomes 1 after that edge.
- Countdown: each edge with counter>0 decrements counter. At the edge where counter==1, commit hi<=pend_hi, lo<=pend_lo and set busy=0.
  - Result: busy is high for exactly N cycles after the accepting edge, and new HI/LO appear in the same cycle busy falls.
- mult: signed 32x32 -> 64; hi=upper, lo=lower. multu: the same, unsigned.
- div (signed): lo=quotient truncated toward zero; hi=remainder with the sign of the dividend a.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (b==0, ops 3/4): still busy for DIV_CYCLES; at completion hi and lo are left unchanged (no commit).
- mthi/mtlo (valid & !busy): hi<=a (or lo<=a) at that edge, single cycle; busy is not asserted.
- Any op arriving while busy==1 is ignored (no restart, no mthi/mtlo write). The hazard unit guarantees this does not occur; the bench checks it anyway.
- op none/invalid or valid==0: no state change except the countdown.
- hi/lo outputs are register values. mfhi/mflo forwarding is outside this block.
- Back-to-back: a new start is accepted on the edge after busy falls (start depends on !busy). Zero idle gap is permitted when valid&op are present that cycle.

Test Plan:
- Reset hold: reset=0 for 2 cycles with op=1, valid=1 -> hi=lo=0, busy=0, stall_req=0 throughout; after release, start=1 combinationally.
- mult a=0xFFFFFFFE(-2), b=3 -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div a=0xFFFFFFF9(-7), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 -> lo=3, hi=1. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero after mthi a=0x1234, mtlo a=0x5678 -> busy 10 cycles; hi stays 0x1234, lo stays 0x5678.
- Op during busy: start mult 4x5, then drive mtlo a=0xDEAD and div ops mid-countdown -> ignored; final lo=20, hi=0; busy length stays 5.
- Reset mid-operation: start div 100/7, assert reset=0 at cycle 3 -> hi=lo=0, busy=0 next cycle; no late commit after release.
